tqv_spi_bus_bridge: RTL and testbench
=====================================

Name: tqv_spi_bus_bridge

Overview:
- Parametrised SPI-slave-to-peripheral-bus bridge for the TinyQV peripheral test harness.
- Converts SPI frames from an external master (cocotb or a real MCU) into peripheral register writes and reads.
- Generalises the fixed 32-bit/6-bit harness path:
  - configurable address and data width;
  - variable access size (byte/half/word);
  - read turnaround with a wait on data_ready;
  - frame abort and illegal-frame rejection.

Parameters:
- ADDR_W, 6: peripheral address width (1..8).
- DATA_W, 32: peripheral data width. Must be ≥ 8<<max size used; 8, 16 or 32.
- SYNC_STAGES, 2: synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (≥2).

Ports:
- clk  in  1  system clock; must be ≥4× spi_sclk frequency.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock, mode 0 (sample on rising, shift on falling).
- spi_cs_n  in  1  frame select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- addr  out  ADDR_W  peripheral register address.
- data_in  out  DATA_W  write data to peripheral, LSB-aligned.
- data_write_n  out  2  write strobe/size: 11 idle, 00 byte, 01 half, 10 word.
- data_read_n  out  2  read request/size, same encoding as data_write_n.
- data_out  in  DATA_W  read data from peripheral.
- data_ready  in  1  read data valid.
- busy  out  1  high while a bus strobe or read is pending.

Behaviour:
- Reset values: spi_miso=0, addr=0, data_in=0, data_write_n=11, data_read_n=11, busy=0, FSM=IDLE. Reset mid-frame or mid-read drops everything; the frame is ignored until spi_cs_n has been seen high.
- Synchronisation and edges:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flops.
  - Rising/falling SCLK edges are detected on the synchronised signal.
  - Bits are counted only while synchronised CS is low.
- Frame format, MSB first: header byte, address byte, then data phase.
  - Header[7]: 1=write, 0=read.
  - Header[6:5]: size S.
  - Header[4:0]: ignored.
  - Address byte: addr takes the low ADDR_W bits.
  - Data phase length N = 8<<S bits.
- FSM states: IDLE → HEADER → ADDR → (WDATA | TURN → RDATA) → DONE.
  - IDLE→HEADER on CS falling.
  - HEADER→ADDR after 8 rising edges.
  - ADDR→WDATA (write) or TURN (read) after 8 rising edges.
  - WDATA→DONE after N rising edges.
  - TURN→RDATA after 8 rising edges.
  - RDATA→DONE after N rising edges.
  - DONE ignores SCLK until CS rises.
  - CS rising in any state → IDLE.
- Illegal frames: S=11, or N>DATA_W → DONE right after HEADER. No bus activity; miso=0.
- Write path:
  - After the last data bit, data_in takes the shifted value zero-extended to DATA_W.
  - data_write_n=S for exactly 1 clk cycle, 1 cycle after the sync'd rising edge of the last bit; then 11.
  - busy is high during that cycle.
- Read path:
  - After the last address bit, data_read_n=S.
  - data_read_n is held until data_ready is sampled high, then returns to 11 the next cycle.
  - data_out[N-1:0] is latched into the read shift register; busy is high throughout the read.
  - If data_ready arrives before TURN ends, RDATA shifts out the latched data.
  - If not, RDATA shifts out all ones. The request stays asserted until data_ready, and that late data is discarded.
  - data_ready in the same cycle the request is raised counts.
- miso: updated on each sync'd falling edge in RDATA; first bit valid before the first RDATA rising edge. Outside RDATA miso=0.
- CS abort:
  - An abort before the write strobe cancels the write.
  - An already-issued read still completes its handshake, with the data discarded.
  - A new frame is accepted only when busy=0. Otherwise it is treated as illegal: DONE, no bus activity.
- addr and data_in hold their last values between frames.

Test Plan:
- Word write: header 0xC0, addr 0x05, data 0xDEADBEEF → one-cycle data_write_n=10, addr=5, data_in=0xDEADBEEF; then 11.
- Byte write: header 0x80, addr 0x3F, data 0xA5 → data_write_n=00 for one cycle, data_in=0x000000A5.
- Read with ready 3 clk after request: header 0x40, addr 0x02, data_out=0x12345678 → data_read_n=10 until ready, 11 one cycle later; miso streams 0x12345678.
- Late ready: hold data_ready low through TURN, header 0x20 → miso returns 0xFFFF; data_read_n=01 stays until ready is raised, then 11; busy drops.
- Abort and illegal size: CS high after 4 write data bits → no write strobe. Header 0x60 → no strobes, miso=0; next legal frame works.
- Reset mid-read: assert rst while data_read_n=10 → next cycle data_read_n=11, busy=0; following frame is accepted after CS toggles.

Source files
------------

// File: rtl/tqv_spi_bus_bridge.sv
// SPI mode-0 slave that turns header/address/data frames into peripheral bus
// writes and reads, with sized strobes, a read turnaround and abort handling.
module tqv_spi_bus_bridge #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [DATA_W-1:0] data_out,
  input  logic              data_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_ADDR, ST_WDATA, ST_TURN, ST_RDATA, ST_DONE
  } state_t;

  function automatic logic [6:0] nbits_f(input logic [1:0] size);
    case (size)
      2'b00:   nbits_f = 7'd8;
      2'b01:   nbits_f = 7'd16;
      2'b10:   nbits_f = 7'd32;
      default: nbits_f = 7'd64;
    endcase
  endfunction

  function automatic logic illegal_f(input logic [1:0] size);
    illegal_f = (size == 2'b11) || (nbits_f(size) > 7'(DATA_W));
  endfunction

  function automatic logic [DATA_W-1:0] mask_f(input logic [1:0] size);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(nbits_f(size)));
    return m;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic                   sclk_d_r, cs_d_r;
  state_t                 state_r, state_n;
  logic [5:0]             cnt_r, cnt_n;
  logic [DATA_W-1:0]      rx_r, rx_n, tx_r, tx_n, rd_data_r, rd_data_n;
  logic [DATA_W-1:0]      data_in_r, data_in_n;
  logic [ADDR_W-1:0]      addr_r, addr_n;
  logic [1:0]             size_r, size_n, wstb_r, wstb_n, rstb_r, rstb_n;
  logic                   wr_r, wr_n, rd_pend_r, rd_pend_n, rd_valid_r, rd_valid_n;
  logic                   miso_r, miso_n, busy_r, busy_n;

  logic              sclk_s, cs_s, mosi_s, rise_s, fall_s, cs_fall_s, cs_rise_s;
  logic              last8_s, lastn_s, rd_hs_s;
  logic [6:0]        n_bits_s;
  logic [7:0]        byte_s;
  logic [DATA_W-1:0] word_s, load_s;

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_d_r & ~cs_s;
  assign fall_s    = ~sclk_s & sclk_d_r & ~cs_s;
  // Sync flops reset low, so a falling CS can only be seen after CS was high.
  assign cs_fall_s = ~cs_s & cs_d_r;
  assign cs_rise_s = cs_s & ~cs_d_r;
  assign n_bits_s  = nbits_f(size_r);
  assign last8_s   = (cnt_r == 6'd7);
  assign lastn_s   = ({1'b0, cnt_r} == (n_bits_s - 7'd1));
  assign word_s    = {rx_r[DATA_W-2:0], mosi_s};
  assign byte_s    = {rx_r[6:0], mosi_s};
  assign rd_hs_s   = rd_pend_r & data_ready;
  assign load_s    = rd_hs_s ? data_out : (rd_valid_r ? rd_data_r : {DATA_W{1'b1}});

  // Input synchronisers and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s;
    end
  end

  // Frame FSM next state plus bus-side handshake.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    rx_n      = rx_r;
    tx_n      = tx_r;
    size_n    = size_r;
    wr_n      = wr_r;
    addr_n    = addr_r;
    data_in_n = data_in_r;
    wstb_n    = 2'b11;
    miso_n    = (state_r == ST_RDATA) ? miso_r : 1'b0;
    if (rd_hs_s) begin
      rd_pend_n = 1'b0;
      rstb_n    = 2'b11;
    end else begin
      rd_pend_n = rd_pend_r;
      rstb_n    = rstb_r;
    end
    // Read data is only kept when it arrives before the turnaround ends.
    if (rd_hs_s && (state_r == ST_TURN)) begin
      rd_data_n  = data_out & mask_f(size_r);
      rd_valid_n = 1'b1;
    end else begin
      rd_data_n  = rd_data_r;
      rd_valid_n = rd_valid_r;
    end
    if (cs_rise_s) begin
      state_n = ST_IDLE;
      cnt_n   = 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_n    = busy_r ? ST_DONE : ST_HEADER;
            cnt_n      = 6'd0;
            rd_valid_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (rise_s) begin
            rx_n = word_s;
            if (last8_s) begin
              cnt_n   = 6'd0;
              wr_n    = byte_s[7];
              size_n  = byte_s[6:5];
              state_n = illegal_f(byte_s[6:5]) ? ST_DONE : ST_ADDR;
            end else begin
              cnt_n = cnt_r + 6'd1;
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            rx_n = word_s;
            if (last8_s) begin
              cnt_n  = 6'd0;
              addr_n = byte_s[ADDR_W-1:0];
              if (wr_r) begin
                state_n = ST_WDATA;
              end else begin
                state_n   = ST_TURN;
                rstb_n    = size_r;
                rd_pend_n = 1'b1;
              end
            end else begin
              cnt_n = cnt_r + 6'd1;
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_WDATA: begin
          if (rise_s) begin
            rx_n = word_s;
            if (lastn_s) begin
              cnt_n     = 6'd0;
              data_in_n = word_s & mask_f(size_r);
              wstb_n    = size_r;
              state_n   = ST_DONE;
            end else begin
              cnt_n = cnt_r + 6'd1;
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_TURN: begin
          if (rise_s && last8_s) begin
            cnt_n   = 6'd0;
            state_n = ST_RDATA;
            tx_n    = load_s << (DATA_W - int'(n_bits_s));
          end else if (rise_s) begin
            cnt_n = cnt_r + 6'd1;
          end else begin
            cnt_n = cnt_r;
          end
        end
        ST_RDATA: begin
          if (rise_s && lastn_s) begin
            cnt_n   = 6'd0;
            state_n = ST_DONE;
          end else if (rise_s) begin
            cnt_n = cnt_r + 6'd1;
          end else begin
            cnt_n = cnt_r;
          end
          if (fall_s) begin
            miso_n = tx_r[DATA_W-1];
            tx_n   = {tx_r[DATA_W-2:0], 1'b0};
          end else begin
            tx_n = tx_r;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
    busy_n = (wstb_n != 2'b11) || rd_pend_n;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 6'd0;
      rx_r       <= {DATA_W{1'b0}};
      tx_r       <= {DATA_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      data_in_r  <= {DATA_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      size_r     <= 2'b00;
      wstb_r     <= 2'b11;
      rstb_r     <= 2'b11;
      wr_r       <= 1'b0;
      rd_pend_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      miso_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      rx_r       <= rx_n;
      tx_r       <= tx_n;
      rd_data_r  <= rd_data_n;
      data_in_r  <= data_in_n;
      addr_r     <= addr_n;
      size_r     <= size_n;
      wstb_r     <= wstb_n;
      rstb_r     <= rstb_n;
      wr_r       <= wr_n;
      rd_pend_r  <= rd_pend_n;
      rd_valid_r <= rd_valid_n;
      miso_r     <= miso_n;
      busy_r     <= busy_n;
    end
  end

  assign spi_miso     = miso_r;
  assign addr         = addr_r;
  assign data_in      = data_in_r;
  assign data_write_n = wstb_r;
  assign data_read_n  = rstb_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_tqv_spi_bus_bridge.sv
// Directed self-checking bench for tqv_spi_bus_bridge: writes, reads, late
// ready, abort, illegal size and reset in the middle of a read.
module tb_tqv_spi_bus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [5:0]  addr;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, busy;

  int checks = 0;
  int failures = 0;

  int          wr_cycles = 0, rd_cycles = 0;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic [5:0]  wr_addr;
  logic        wr_busy;

  tqv_spi_bus_bridge #(.ADDR_W(6), .DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .addr(addr), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record every bus strobe cycle so frames can be checked afterwards.
  always @(negedge clk) begin
    if (data_write_n !== 2'b11) begin
      wr_cycles <= wr_cycles + 1;
      wr_size   <= data_write_n;
      wr_data   <= data_in;
      wr_addr   <= addr;
      wr_busy   <= busy;
    end
    if (data_read_n !== 2'b11) rd_cycles <= rd_cycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [63:0] tx, input int n, output logic [63:0] rx);
    rx = 64'd0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80;
      rx = {rx[62:0], spi_miso};
      spi_sclk = 1'b1;
      #80;
      spi_sclk = 1'b0;
    end
    spi_mosi = 1'b0;
  endtask

  task automatic frame(input logic [63:0] tx, input int n, output logic [63:0] rx);
    spi_cs_n = 1'b0;
    #80;
    spi_bits(tx, n, rx);
    #80;
    spi_cs_n = 1'b1;
    #160;
  endtask

  task automatic respond(input int dly, input logic [1:0] sz, input logic [5:0] a,
                         input logic [31:0] dat);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (data_read_n !== 2'b11) seen = 1'b1;
    end
    check("rd_req_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("rd_req_size", 64'(data_read_n), 64'(sz));
      check("rd_req_addr", 64'(addr), 64'(a));
      check("rd_req_busy", 64'(busy), 64'd1);
      repeat (dly) @(negedge clk);
      check("rd_req_held", 64'(data_read_n), 64'(sz));
      check("rd_busy_held", 64'(busy), 64'd1);
      data_out   = dat;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      data_out   = 32'd0;
      check("rd_release", 64'(data_read_n), 64'd3);
      check("rd_busy_drop", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rx;
    int w0, r0;
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    data_out = 32'd0; data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data_in", 64'(data_in), 64'd0);
    check("rst_write_n", 64'(data_write_n), 64'd3);
    check("rst_read_n", 64'(data_read_n), 64'd3);
    check("rst_busy", 64'(busy), 64'd0);

    // Word write
    w0 = wr_cycles;
    frame({16'h0, 8'hC0, 8'h05, 32'hDEADBEEF}, 48, rx);
    check("wword_cycles", 64'(wr_cycles - w0), 64'd1);
    check("wword_size", 64'(wr_size), 64'd2);
    check("wword_data", 64'(wr_data), 64'hDEADBEEF);
    check("wword_addr", 64'(wr_addr), 64'd5);
    check("wword_busy", 64'(wr_busy), 64'd1);
    check("wword_idle", 64'(data_write_n), 64'd3);
    check("wword_hold", 64'(data_in), 64'hDEADBEEF);
    check("wword_busy_after", 64'(busy), 64'd0);

    // Byte write
    w0 = wr_cycles;
    frame({40'h0, 8'h80, 8'h3F, 8'hA5}, 24, rx);
    check("wbyte_cycles", 64'(wr_cycles - w0), 64'd1);
    check("wbyte_size", 64'(wr_size), 64'd0);
    check("wbyte_data", 64'(wr_data), 64'h000000A5);
    check("wbyte_addr", 64'(wr_addr), 64'h3F);

    // Word read, ready three cycles after the request
    w0 = wr_cycles; r0 = rd_cycles;
    fork
      frame({8'h40, 8'h02, 8'h00, 32'h0}, 56, rx);
      respond(3, 2'b10, 6'h02, 32'h12345678);
    join
    check("rword_miso", 64'(rx[31:0]), 64'h12345678);
    check("rword_miso_pre", 64'(rx[55:32]), 64'd0);
    check("rword_req_cycles", 64'(rd_cycles - r0), 64'd4);
    check("rword_no_write", 64'(wr_cycles - w0), 64'd0);
    check("rword_miso_idle", 64'(spi_miso), 64'd0);

    // Half read with ready long after the turnaround
    r0 = rd_cycles;
    fork
      frame({24'h0, 8'h20, 8'h11, 8'h00, 16'h0}, 40, rx);
      respond(500, 2'b01, 6'h11, 32'h0000ABCD);
    join
    check("rlate_miso", 64'(rx[15:0]), 64'hFFFF);
    check("rlate_req_cycles", 64'(rd_cycles - r0), 64'd501);
    check("rlate_read_n", 64'(data_read_n), 64'd3);

    // Abort after four write data bits
    w0 = wr_cycles;
    frame({44'h0, 8'h80, 8'h07, 4'hF}, 20, rx);
    check("abort_no_write", 64'(wr_cycles - w0), 64'd0);
    check("abort_data_in", 64'(data_in), 64'h000000A5);

    // Illegal size
    w0 = wr_cycles; r0 = rd_cycles;
    frame({40'h0, 8'h60, 8'h01, 8'hFF}, 24, rx);
    check("illegal_no_write", 64'(wr_cycles - w0), 64'd0);
    check("illegal_no_read", 64'(rd_cycles - r0), 64'd0);
    check("illegal_miso", 64'(rx[23:0]), 64'd0);

    // Legal frame after the illegal one
    w0 = wr_cycles;
    frame({40'h0, 8'h80, 8'h2A, 8'h3C}, 24, rx);
    check("after_ill_cycles", 64'(wr_cycles - w0), 64'd1);
    check("after_ill_size", 64'(wr_size), 64'd0);
    check("after_ill_data", 64'(wr_data), 64'h3C);
    check("after_ill_addr", 64'(wr_addr), 64'h2A);

    // Reset while a word read request is outstanding
    spi_cs_n = 1'b0;
    #80;
    spi_bits({48'h0, 8'h40, 8'h09}, 16, rx);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (data_read_n !== 2'b11) seen = 1'b1;
      end
      check("rstrd_req_seen", 64'(seen), 64'd1);
    end
    check("rstrd_req_size", 64'(data_read_n), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrd_read_n", 64'(data_read_n), 64'd3);
    check("rstrd_busy", 64'(busy), 64'd0);
    check("rstrd_addr", 64'(addr), 64'd0);
    check("rstrd_data_in", 64'(data_in), 64'd0);
    w0 = wr_cycles; r0 = rd_cycles;
    spi_bits({56'h0, 8'hFF}, 8, rx);
    check("rstrd_ignored_miso", 64'(rx[7:0]), 64'd0);
    check("rstrd_ignored_wr", 64'(wr_cycles - w0), 64'd0);
    check("rstrd_ignored_rd", 64'(rd_cycles - r0), 64'd0);
    #80;
    spi_cs_n = 1'b1;
    #160;
    w0 = wr_cycles;
    frame({40'h0, 8'h80, 8'h01, 8'h5A}, 24, rx);
    check("rstrd_next_cycles", 64'(wr_cycles - w0), 64'd1);
    check("rstrd_next_data", 64'(wr_data), 64'h5A);
    check("rstrd_next_addr", 64'(wr_addr), 64'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
